mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 The block SHALL have parameter TIMEOUT, default 255, maximum ACCESS cycles waiting for memAck before abort (1..65535).
REQ-004 The block SHALL have one clock and an asynchronous active-low reset: clk input 1 rising-edge clock; rstN input 1 asynchronous active-low reset.
REQ-005 coreRead input 4: per-core memRead request, bit i = core i.
REQ-006 coreWrite input 4: per-core memWrite request.
REQ-007 coreAddr input 4*ADDR_W: packed addresses, core i at [i*ADDR_W +: ADDR_W].
REQ-008 coreWdata input 4*DATA_W: packed write data, same packing.
REQ-009 coreReady output 4: one-cycle completion pulse per core.
REQ-010 coreErr output 4: one-cycle timeout error pulse, coincident with coreReady.
REQ-011 coreRdata output DATA_W: read data, shared by all cores, valid while coreReady is high.
REQ-012 memReq output 1; memWe output 1; memAddr output ADDR_W; memWdata output DATA_W: shared memory port request.
REQ-013 memRdata input DATA_W; memAck input 1: memory response.
REQ-014 busy output 1: high in any state other than IDLE.

Function
REQ-015 FSM SHALL have exactly three states: IDLE, ACCESS, RESP.
REQ-016 A core i is requesting when coreRead[i] | coreWrite[i]; requests SHALL be sampled only in IDLE.
REQ-017 In IDLE with any request, the winner SHALL be the first requesting core scanning upward from ptr with wrap 3->0; grant, address, write data and we (= coreWrite of winner) SHALL be registered and the FSM SHALL enter ACCESS next cycle.
REQ-018 If a core asserts both coreRead and coreWrite, the access SHALL be a write.
REQ-019 In ACCESS, memReq SHALL be 1 and memWe/memAddr/memWdata SHALL hold the registered values, stable until exit; outside ACCESS memReq and memWe SHALL be 0.
REQ-020 memAck SHALL be sampled only in ACCESS; memAck in ACCESS SHALL latch memRdata (reads; writes latch 0) into coreRdata and enter RESP.
REQ-021 A 16-bit wait counter SHALL clear on ACCESS entry and increment each ACCESS cycle without memAck; on reaching TIMEOUT the FSM SHALL enter RESP with error flagged and coreRdata = 0.
REQ-022 memAck in the same cycle the counter reaches TIMEOUT SHALL count as success, no error.
REQ-023 In RESP, coreReady[grant] SHALL be 1 for exactly one cycle, coreErr[grant] SHALL equal the error flag, ptr SHALL update to (grant+1) mod 4, and the FSM SHALL return to IDLE.
REQ-024 Minimum latency: request sampled at edge N, memReq high in cycle N+1, memAck in N+1 gives coreReady in cycle N+2; one access per 3 cycles maximum.
REQ-025 Request withdrawal during ACCESS/RESP SHALL not abort the transaction; cores SHALL hold requests until coreReady and drop them the following cycle.
REQ-026 coreRdata SHALL hold its last value outside RESP; non-granted coreReady/coreErr bits SHALL be 0.

Reset
REQ-027 rstN low SHALL asynchronously force IDLE, ptr = 0, counter = 0, grant = 0, and all outputs (coreReady, coreErr, coreRdata, memReq, memWe, memAddr, memWdata, busy) to 0.
REQ-028 Reset asserted mid-ACCESS SHALL drop memReq immediately with no coreReady pulse; after release the pending core SHALL be re-arbitrated from ptr = 0.

Verification
REQ-029 After reset, coreRead = 4'b1111, memAck one cycle after memReq each time -> grant order 0,1,2,3,0; each coreReady pulse 1 cycle; busy low only one cycle between accesses.
REQ-030 Core 2 write addr 0x100 data 0xDEADBEEF, memAck in first ACCESS cycle -> memReq=1, memWe=1, memAddr=0x100, memWdata=0xDEADBEEF; coreReady = 4'b0100 two cycles after request sampled.
REQ-031 Core 1 read, memAck after 3 wait cycles with memRdata 0x12345678 -> memReq high 4 cycles, coreRdata 0x12345678 with coreReady[1], coreErr 0.
REQ-032 TIMEOUT = 4, core 3 read, memAck never -> memReq high for 4 cycles then coreReady[3]=1, coreErr[3]=1, coreRdata=0; memAck on 4th cycle -> coreErr=0.
REQ-033 Core 0 sets coreRead and coreWrite together -> memWe=1; rstN pulsed low mid-ACCESS -> memReq, busy, all outputs 0 immediately, no coreReady.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter -- round-robin arbiter granting four cores one shared memory port, with a per-access timeout.
// Revision: 1.0
`default_nettype none

module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic [3:0]            coreRead,
  input  logic [3:0]            coreWrite,
  input  logic [4*ADDR_W-1:0]   coreAddr,
  input  logic [4*DATA_W-1:0]   coreWdata,
  output logic [3:0]            coreReady,
  output logic [3:0]            coreErr,
  output logic [DATA_W-1:0]     coreRdata,
  output logic                  memReq,
  output logic                  memWe,
  output logic [ADDR_W-1:0]     memAddr,
  output logic [DATA_W-1:0]     memWdata,
  input  logic [DATA_W-1:0]     memRdata,
  input  logic                  memAck,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Counter value at which one more ACCESS cycle without memAck reaches TIMEOUT.
  localparam logic [15:0] c_wait_last = 16'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_ptr;
  logic [1:0]  r_grant;
  logic        r_we;
  logic        r_err;
  logic [15:0] r_cnt;

  logic [3:0]  w_req;
  logic [3:0]  w_rot;
  logic [1:0]  w_off;
  logic [1:0]  w_winner;
  logic        w_any;
  logic        w_wait_done;

  // Rotate so bit 0 is the core at ptr; the lowest set bit is then the winner's offset.
  always_comb begin
    w_req = coreRead | coreWrite;
    w_any = |w_req;
    w_rot = (w_req >> r_ptr) | (w_req << (3'd4 - {1'b0, r_ptr}));
    w_off = 2'd0;
    if (w_rot[0])      w_off = 2'd0;
    else if (w_rot[1]) w_off = 2'd1;
    else if (w_rot[2]) w_off = 2'd2;
    else if (w_rot[3]) w_off = 2'd3;
    w_winner = r_ptr + w_off;
  end

  assign w_wait_done = (r_cnt == c_wait_last);

  always_comb begin
    w_state_nxt = r_state;
    memReq      = 1'b0;
    memWe       = 1'b0;
    busy        = 1'b1;
    coreReady   = 4'b0000;
    coreErr     = 4'b0000;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (w_any) w_state_nxt = ACCESS;
      end
      ACCESS: begin
        memReq = 1'b1;
        memWe  = r_we;
        if (memAck || w_wait_done) w_state_nxt = RESP;
      end
      RESP: begin
        coreReady = 4'(1) << r_grant;
        coreErr   = r_err ? (4'(1) << r_grant) : 4'b0000;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state   <= IDLE;
      r_ptr     <= 2'd0;
      r_grant   <= 2'd0;
      r_we      <= 1'b0;
      r_err     <= 1'b0;
      r_cnt     <= 16'd0;
      memAddr   <= '0;
      memWdata  <= '0;
      coreRdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant  <= w_winner;
            r_we     <= coreWrite[w_winner];
            r_err    <= 1'b0;
            r_cnt    <= 16'd0;
            memAddr  <= coreAddr[int'(w_winner)*ADDR_W +: ADDR_W];
            memWdata <= coreWdata[int'(w_winner)*DATA_W +: DATA_W];
          end
        end
        ACCESS: begin
          // A late memAck on the final allowed cycle still wins over the timeout.
          if (memAck) begin
            coreRdata <= r_we ? '0 : memRdata;
            r_err     <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
            if (w_wait_done) begin
              coreRdata <= '0;
              r_err     <= 1'b1;
            end
          end
        end
        RESP: begin
          r_ptr <= r_grant + 2'd1;
        end
        default: begin
          r_ptr <= r_ptr;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- self-checking bench for mem_arbiter against a transaction-level reference model.
// Revision: 1.0
`default_nettype none

module tb_mem_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 4;

  logic                clk = 1'b0;
  logic                rstN = 1'b0;
  logic [3:0]          coreRead = '0;
  logic [3:0]          coreWrite = '0;
  logic [4*ADDR_W-1:0] coreAddr = '0;
  logic [4*DATA_W-1:0] coreWdata = '0;
  logic [3:0]          coreReady;
  logic [3:0]          coreErr;
  logic [DATA_W-1:0]   coreRdata;
  logic                memReq;
  logic                memWe;
  logic [ADDR_W-1:0]   memAddr;
  logic [DATA_W-1:0]   memWdata;
  logic [DATA_W-1:0]   memRdata = '0;
  logic                memAck = 1'b0;
  logic                busy;

  int checks = 0;
  int errors = 0;
  int m_ptr = 0;
  logic [DATA_W-1:0] m_rdata = '0;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstN(rstN),
    .coreRead(coreRead), .coreWrite(coreWrite),
    .coreAddr(coreAddr), .coreWdata(coreWdata),
    .coreReady(coreReady), .coreErr(coreErr), .coreRdata(coreRdata),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
    .memRdata(memRdata), .memAck(memAck), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int pick(input logic [3:0] req, input int ptr);
    for (int k = 0; k < 4; k++)
      if (req[(ptr + k) % 4]) return (ptr + k) % 4;
    return -1;
  endfunction

  task automatic set_core(input int i, input bit rd, input bit wr,
                          input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    coreRead[i]  = rd;
    coreWrite[i] = wr;
    coreAddr[i*ADDR_W +: ADDR_W] = a;
    coreWdata[i*DATA_W +: DATA_W] = d;
  endtask

  // One transaction from an IDLE negedge through RESP back to the next IDLE negedge.
  task automatic run_txn(input int delay, input logic [DATA_W-1:0] mdata, input bit drop,
                         output int w, output int hc, output logic [3:0] seen_err,
                         output logic seen_we);
    logic [3:0] req;
    logic exp_we, exp_err;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_wd, exp_rd;
    logic [3:0] exp_rdy;
    int cyc;
    bit done;
    req = coreRead | coreWrite;
    w = pick(req, m_ptr);
    hc = 0; seen_err = '0; seen_we = 1'b0;
    if (w < 0) begin
      checks++; errors++;
      $display("FAIL run_txn_no_request: got req=%b required nonzero", req);
      return;
    end
    exp_we   = coreWrite[w];
    exp_addr = coreAddr[w*ADDR_W +: ADDR_W];
    exp_wd   = coreWdata[w*DATA_W +: DATA_W];
    exp_err  = (delay + 1 > TIMEOUT);
    exp_rdy  = 4'(1 << w);
    checks++;
    if (busy !== 1'b0 || memReq !== 1'b0) begin
      errors++;
      $display("FAIL idle_state: got busy=%b memReq=%b required 0 0", busy, memReq);
    end
    @(negedge clk);
    cyc = 0; done = 0;
    while (!done) begin
      cyc++;
      if (memReq === 1'b1) hc++;
      if (cyc == 1) seen_we = memWe;
      checks++;
      if ({memReq, memWe, memAddr, memWdata} !== {1'b1, exp_we, exp_addr, exp_wd}) begin
        errors++;
        $display("FAIL access_port: got req=%b we=%b addr=%h wd=%h required 1 %b %h %h",
                 memReq, memWe, memAddr, memWdata, exp_we, exp_addr, exp_wd);
      end
      checks++;
      if (coreReady !== 4'b0 || busy !== 1'b1 || coreRdata !== m_rdata) begin
        errors++;
        $display("FAIL access_hold: got rdy=%b busy=%b rdata=%h required 0000 1 %h",
                 coreReady, busy, coreRdata, m_rdata);
      end
      memAck   = (cyc == delay + 1);
      memRdata = memAck ? mdata : DATA_W'($urandom);
      if (memAck || cyc >= TIMEOUT) done = 1;
      @(negedge clk);
    end
    memAck = 1'b0;
    exp_rd = (exp_err || exp_we) ? '0 : mdata;
    seen_err = coreErr;
    checks++;
    if (coreReady !== exp_rdy || coreErr !== (exp_err ? exp_rdy : 4'b0)) begin
      errors++;
      $display("FAIL resp_pulse: got rdy=%b err=%b required %b %b",
               coreReady, coreErr, exp_rdy, exp_err ? exp_rdy : 4'b0);
    end
    checks++;
    if (coreRdata !== exp_rd || memReq !== 1'b0 || memWe !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL resp_data: got rdata=%h req=%b we=%b busy=%b required %h 0 0 1",
               coreRdata, memReq, memWe, busy, exp_rd);
    end
    m_rdata = exp_rd;
    m_ptr = (w + 1) % 4;
    if (drop) begin
      coreRead[w]  = 1'b0;
      coreWrite[w] = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || coreReady !== 4'b0 || coreErr !== 4'b0 || coreRdata !== m_rdata) begin
      errors++;
      $display("FAIL after_resp: got busy=%b rdy=%b err=%b rdata=%h required 0 0000 0000 %h",
               busy, coreReady, coreErr, coreRdata, m_rdata);
    end
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({coreReady, coreErr, coreRdata, memReq, memWe, memAddr, memWdata, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b err=%b rdata=%h req=%b we=%b addr=%h wd=%h busy=%b required all 0",
               coreReady, coreErr, coreRdata, memReq, memWe, memAddr, memWdata, busy);
    end
    rstN = 1'b1;
    m_ptr = 0;
    m_rdata = '0;
  endtask

  task automatic test_round_robin();
    int w, hc; logic [3:0] se; logic sw;
    coreRead = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      run_txn(0, DATA_W'($urandom), 0, w, hc, se, sw);
      checks++;
      if (w != i % 4) begin
        errors++;
        $display("FAIL rr_order[%0d]: got model winner %0d required %0d", i, w, i % 4);
      end
    end
    coreRead = 4'b0000;
  endtask

  task automatic test_write_core2();
    int w, hc; logic [3:0] se; logic sw;
    set_core(2, 0, 1, 32'h100, 32'hDEADBEEF);
    run_txn(0, 32'h5555AAAA, 1, w, hc, se, sw);
    checks++;
    if (w != 2 || hc != 1 || sw !== 1'b1) begin
      errors++;
      $display("FAIL write_core2: got w=%0d memReq_cycles=%0d we=%b required 2 1 1", w, hc, sw);
    end
  endtask

  task automatic test_read_wait();
    int w, hc; logic [3:0] se; logic sw;
    set_core(1, 1, 0, 32'h2000, 32'h0);
    run_txn(3, 32'h12345678, 1, w, hc, se, sw);
    checks++;
    if (hc != 4 || se !== 4'b0000 || coreRdata !== 32'h12345678) begin
      errors++;
      $display("FAIL read_wait: got memReq_cycles=%0d err=%b rdata=%h required 4 0000 12345678",
               hc, se, coreRdata);
    end
  endtask

  task automatic test_timeout();
    int w, hc; logic [3:0] se; logic sw;
    set_core(3, 1, 0, 32'h3000, 32'h0);
    run_txn(100, 32'hCAFEF00D, 1, w, hc, se, sw);
    checks++;
    if (hc != 4 || se !== 4'b1000 || coreRdata !== 32'h0) begin
      errors++;
      $display("FAIL timeout_abort: got memReq_cycles=%0d err=%b rdata=%h required 4 1000 0",
               hc, se, coreRdata);
    end
    set_core(3, 1, 0, 32'h3004, 32'h0);
    run_txn(3, 32'hCAFEF00D, 1, w, hc, se, sw);
    checks++;
    if (hc != 4 || se !== 4'b0000 || coreRdata !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL timeout_last_ack: got memReq_cycles=%0d err=%b rdata=%h required 4 0000 cafef00d",
               hc, se, coreRdata);
    end
  endtask

  task automatic test_read_write_both();
    int w, hc; logic [3:0] se; logic sw;
    set_core(0, 1, 1, 32'h40, 32'h0BADF00D);
    run_txn(0, 32'h77777777, 1, w, hc, se, sw);
    checks++;
    if (sw !== 1'b1 || w != 0 || coreRdata !== 32'h0) begin
      errors++;
      $display("FAIL both_is_write: got we=%b w=%0d rdata=%h required 1 0 0", sw, w, coreRdata);
    end
  endtask

  // Model ptr is 1 here, so core 3 wins first; after reset core 0 must win.
  task automatic test_reset_mid_access();
    int w, hc; logic [3:0] se; logic sw;
    set_core(0, 1, 0, 32'hA0, 32'h0);
    set_core(3, 1, 0, 32'hA3, 32'h0);
    @(negedge clk);
    checks++;
    if (memReq !== 1'b1 || memAddr !== 32'hA3) begin
      errors++;
      $display("FAIL pre_reset_grant: got req=%b addr=%h required 1 a3", memReq, memAddr);
    end
    #2 rstN = 1'b0;
    #1;
    checks++;
    if ({coreReady, coreErr, coreRdata, memReq, memWe, memAddr, memWdata, busy} !== '0) begin
      errors++;
      $display("FAIL async_reset: got rdy=%b err=%b rdata=%h req=%b addr=%h busy=%b required all 0",
               coreReady, coreErr, coreRdata, memReq, memAddr, busy);
    end
    @(negedge clk);
    checks++;
    if (coreReady !== 4'b0 || memReq !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_ready: got rdy=%b req=%b required 0000 0", coreReady, memReq);
    end
    rstN = 1'b1;
    m_ptr = 0;
    m_rdata = '0;
    run_txn(0, 32'h11112222, 1, w, hc, se, sw);
    checks++;
    if (w != 0) begin
      errors++;
      $display("FAIL rearb_first: got winner %0d required 0", w);
    end
    run_txn(0, 32'h33334444, 1, w, hc, se, sw);
    checks++;
    if (w != 3) begin
      errors++;
      $display("FAIL rearb_second: got winner %0d required 3", w);
    end
  endtask

  task automatic test_random();
    int w, hc; logic [3:0] se; logic sw;
    int c;
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < 4; i++) begin
        if (!(coreRead[i] | coreWrite[i]) && $urandom_range(0, 1) == 1) begin
          c = $urandom_range(1, 3);
          set_core(i, c[0], c[1], ADDR_W'($urandom), DATA_W'($urandom));
        end
      end
      if ((coreRead | coreWrite) == 4'b0) begin
        c = $urandom_range(0, 3);
        set_core(c, 1, 0, ADDR_W'($urandom), DATA_W'($urandom));
      end
      run_txn($urandom_range(0, 6), DATA_W'($urandom), 1, w, hc, se, sw);
    end
    coreRead  = 4'b0;
    coreWrite = 4'b0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_write_core2();
    test_read_wait();
    test_timeout();
    test_read_write_both();
    test_reset_mid_access();
    test_random();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
